fifo_block_pack: RTL and testbench

FIFO_BLOCK_PACK -- requirements
Module: fifo_block_pack

---
 rtl/fifo_block_pack_if.sv | 45 ++++
 rtl/fifo_block_pack.sv | 122 ++++++++++++
 tb/tb_fifo_block_pack.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_block_pack_if.sv
// Handshake bundle for fifo_block_pack: word writes in, packed blocks out.
// Error flags exist only when FIFO_BLOCK_PACK_ERR_EN is defined.
interface fifo_block_pack_if #(
   parameter int DATA_IN_WH  = 32,
   parameter int BLOCK_WORDS = 4,
   parameter int DEPTH       = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int WC_W  = $clog2(BLOCK_WORDS);

   logic                              clear;
   logic                              write_fifo;
   logic [DATA_IN_WH-1:0]             data_in;
   logic                              read_fifo;
   logic [DATA_IN_WH*BLOCK_WORDS-1:0] data_out;
   logic                              empty_fifo;
   logic                              full_fifo;
   logic                              almost_full;
   logic [CNT_W-1:0]                  counter_fifo;
   logic [WC_W-1:0]                   word_cnt;
`ifdef FIFO_BLOCK_PACK_ERR_EN
   logic                              overflow_err;
   logic                              underflow_err;

   modport master (
      output clear, write_fifo, data_in, read_fifo,
      input  data_out, empty_fifo, full_fifo, almost_full, counter_fifo, word_cnt,
             overflow_err, underflow_err
   );
   modport slave (
      input  clear, write_fifo, data_in, read_fifo,
      output data_out, empty_fifo, full_fifo, almost_full, counter_fifo, word_cnt,
             overflow_err, underflow_err
   );
`else
   modport master (
      output clear, write_fifo, data_in, read_fifo,
      input  data_out, empty_fifo, full_fifo, almost_full, counter_fifo, word_cnt
   );
   modport slave (
      input  clear, write_fifo, data_in, read_fifo,
      output data_out, empty_fifo, full_fifo, almost_full, counter_fifo, word_cnt
   );
`endif
endinterface

// File: rtl/fifo_block_pack.sv
// Packs BLOCK_WORDS input words MSB-first into blocks and queues DEPTH blocks, show-ahead.
// Define FIFO_BLOCK_PACK_ERR_EN to add sticky overflow_err / underflow_err flags.
module fifo_block_pack #(
   parameter int DATA_IN_WH     = 32,
   parameter int BLOCK_WORDS    = 4,
   parameter int DEPTH          = 4,
   parameter int ALMOST_FULL_TH = DEPTH - 1
) (
   input logic              clk,
   input logic              reset,
   fifo_block_pack_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = $clog2(BLOCK_WORDS);
   localparam int BLK_W = DATA_IN_WH * BLOCK_WORDS;
   localparam logic [WC_W-1:0] LAST_WC = WC_W'(BLOCK_WORDS - 1);

   logic [BLK_W-1:0] mem_q [DEPTH];
   logic [BLK_W-1:0] part_q, part_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WC_W-1:0]  wc_q, wc_d;
   logic             wr_acc, commit, pop, mem_we;
   logic             empty, full;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      part_d   = part_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      wc_d     = wc_q;
      wr_acc   = bus.write_fifo && !full;
      commit   = wr_acc && (wc_q == LAST_WC);
      pop      = bus.read_fifo && !empty;
      mem_we   = 1'b0;

      if (bus.clear) begin
         part_d   = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         wc_d     = '0;
      end else begin
         if (wr_acc) begin
            // Shifting left lands word 0 in the top slot once the block is complete.
            part_d = {part_q[BLK_W-DATA_IN_WH-1:0], bus.data_in};
            wc_d   = commit ? '0 : wc_q + WC_W'(1);
         end
         if (commit) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({commit, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         part_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wc_q     <= '0;
      end else begin
         part_q   <= part_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wc_q     <= wc_d;
      end
   end

   // NOTE: storage is deliberately not reset; data_out masks it whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_ptr_q] <= part_d;
   end

   assign bus.data_out     = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.empty_fifo   = empty;
   assign bus.full_fifo    = full;
   assign bus.almost_full  = (count_q >= CNT_W'(ALMOST_FULL_TH));
   assign bus.counter_fifo = count_q;
   assign bus.word_cnt     = wc_q;

`ifdef FIFO_BLOCK_PACK_ERR_EN
   logic ovf_q, ovf_d, und_q, und_d;

   always_comb begin
      ovf_d = ovf_q | (bus.write_fifo & full);
      und_d = und_q | (bus.read_fifo & empty);
      if (bus.clear) begin
         ovf_d = 1'b0;
         und_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         und_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         und_q <= und_d;
      end
   end

   assign bus.overflow_err  = ovf_q;
   assign bus.underflow_err = und_q;
`endif
endmodule

// File: tb/tb_fifo_block_pack.sv
// Scoreboard bench for fifo_block_pack at default parameters (W=32, 4 words/block, depth 4).
module tb_fifo_block_pack;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fifo_block_pack_if bus ();
   fifo_block_pack dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int failures = 0;
   logic [127:0] sb[$];

   int           m_cnt;
   int           m_wc;
   logic [127:0] m_part;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One clock of stimulus; the expected block is queued when the write completes one.
   task automatic do_cycle(input logic wr, input logic [31:0] d, input logic rd);
      bit acc_w, commit, pop;
      acc_w  = wr && (m_cnt != 4);
      commit = acc_w && (m_wc == 3);
      pop    = rd && (m_cnt != 0);
      if (commit) sb.push_back({m_part[95:0], d});
      bus.write_fifo = wr;
      bus.data_in    = d;
      bus.read_fifo  = rd;
      step();
      bus.write_fifo = 1'b0;
      bus.read_fifo  = 1'b0;
      if (acc_w) begin
         m_part = {m_part[95:0], d};
         m_wc   = (m_wc == 3) ? 0 : m_wc + 1;
      end
      m_cnt = m_cnt + int'(commit) - int'(pop);
   endtask

   task automatic write_block(input logic [31:0] base);
      for (int k = 0; k < 4; k++) do_cycle(1'b1, base + 32'(k), 1'b0);
   endtask

   // Monitor: each accepted pop must present the oldest queued block.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.read_fifo && !bus.empty_fifo && !bus.clear && !reset) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pop_unexpected: got %h expected no block", bus.data_out);
            end else begin
               check("pop_data", bus.data_out, sb.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.clear = 1'b0; bus.write_fifo = 1'b0; bus.read_fifo = 1'b0; bus.data_in = '0;
      m_cnt = 0; m_wc = 0; m_part = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("rst_counter", bus.counter_fifo, 0);
      check("rst_word_cnt", bus.word_cnt, 0);
      check("rst_empty", bus.empty_fifo, 1);
      check("rst_full", bus.full_fifo, 0);
      check("rst_almost_full", bus.almost_full, 0);
      check("rst_data_out", bus.data_out, 0);
`ifdef FIFO_BLOCK_PACK_ERR_EN
      check("rst_ovf", bus.overflow_err, 0);
      check("rst_und", bus.underflow_err, 0);
`endif
      #1 reset = 1'b0;

      // First block written from the very first edge; word_cnt steps 1,2,3,0.
      do_cycle(1'b1, 32'h00010203, 1'b0); check("wc_1", bus.word_cnt, 1);
      do_cycle(1'b1, 32'h04050607, 1'b0); check("wc_2", bus.word_cnt, 2);
      do_cycle(1'b1, 32'h08090A0B, 1'b0); check("wc_3", bus.word_cnt, 3);
      check("partial_hidden", bus.empty_fifo, 1);
      do_cycle(1'b1, 32'h0C0D0E0F, 1'b0); check("wc_0", bus.word_cnt, 0);
      check("blk0_data", bus.data_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("blk0_count", bus.counter_fifo, 1);
      check("blk0_empty", bus.empty_fifo, 0);

      // Fill to full; almost_full from 3 blocks.
      write_block(32'hA0000100);
      check("cnt2", bus.counter_fifo, 2);
      check("af_cnt2", bus.almost_full, 0);
      write_block(32'hA0000200);
      check("af_cnt3", bus.almost_full, 1);
      check("full_cnt3", bus.full_fifo, 0);
      write_block(32'hA0000300);
      check("cnt4", bus.counter_fifo, 4);
      check("full_cnt4", bus.full_fifo, 1);
      check("af_cnt4", bus.almost_full, 1);
      do_cycle(1'b1, 32'hDEADBEEF, 1'b0);
      check("drop_wc", bus.word_cnt, 0);
      check("drop_cnt", bus.counter_fifo, 4);
`ifdef FIFO_BLOCK_PACK_ERR_EN
      check("ovf_set", bus.overflow_err, 1);
`endif
      check("head_after_drop", bus.data_out, 128'h000102030405060708090A0B0C0D0E0F);

      // Drain all four; pointers are back at 0 afterwards.
      for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1);
      check("drain_empty", bus.empty_fifo, 1);
      check("drain_data_zero", bus.data_out, 0);
      check("drain_full", bus.full_fifo, 0);
      write_block(32'h11110000);
      check("wrap_data", bus.data_out, 128'h11110000111100011111000211110003);
      check("wrap_cnt", bus.counter_fifo, 1);

      // Commit and pop in the same edge.
      write_block(32'h22220000);
      for (int k = 0; k < 3; k++) do_cycle(1'b1, 32'h33330000 + 32'(k), 1'b0);
      check("pre_sim_wc", bus.word_cnt, 3);
      check("pre_sim_cnt", bus.counter_fifo, 2);
      do_cycle(1'b1, 32'h33330003, 1'b1);
      check("sim_cnt", bus.counter_fifo, 2);
      check("sim_wc", bus.word_cnt, 0);
      check("sim_head", bus.data_out, 128'h22220000222200012222000222220003);
      do_cycle(1'b0, '0, 1'b1);
      check("sim_tail", bus.data_out, 128'h33330000333300013333000233330003);
      do_cycle(1'b0, '0, 1'b1);
      check("sim_empty", bus.empty_fifo, 1);

      // Pop on empty, then clear over a partial block and a concurrent write.
      do_cycle(1'b0, '0, 1'b1);
      check("uf_cnt", bus.counter_fifo, 0);
      check("uf_data", bus.data_out, 0);
      check("uf_empty", bus.empty_fifo, 1);
`ifdef FIFO_BLOCK_PACK_ERR_EN
      check("und_set", bus.underflow_err, 1);
`endif
      do_cycle(1'b1, 32'h44440000, 1'b0);
      do_cycle(1'b1, 32'h44440001, 1'b0);
      check("clr_pre_wc", bus.word_cnt, 2);
      bus.clear = 1'b1; bus.write_fifo = 1'b1; bus.data_in = 32'h44440002;
      step();
      bus.clear = 1'b0; bus.write_fifo = 1'b0;
      m_wc = 0; m_part = '0; m_cnt = 0;
      check("clr_wc", bus.word_cnt, 0);
      check("clr_cnt", bus.counter_fifo, 0);
`ifdef FIFO_BLOCK_PACK_ERR_EN
      check("clr_ovf", bus.overflow_err, 0);
      check("clr_und", bus.underflow_err, 0);
`endif
      write_block(32'h55550000);
      check("post_clr_data", bus.data_out, 128'h55550000555500015555000255550003);
      do_cycle(1'b0, '0, 1'b1);

      // Asynchronous reset between edges with three blocks and a partial word held.
      write_block(32'h66000000);
      write_block(32'h66000100);
      write_block(32'h66000200);
      do_cycle(1'b1, 32'h66000300, 1'b0);
      check("pre_rst_cnt", bus.counter_fifo, 3);
      #1 reset = 1'b1;
      #1;
      check("async_cnt", bus.counter_fifo, 0);
      check("async_empty", bus.empty_fifo, 1);
      check("async_data", bus.data_out, 0);
      check("async_wc", bus.word_cnt, 0);
      check("async_af", bus.almost_full, 0);
      sb.delete();
      m_cnt = 0; m_wc = 0; m_part = '0;
      step();
      reset = 1'b0;
      write_block(32'h77770000);
      check("post_rst_data", bus.data_out, 128'h77770000777700017777000277770003);
      do_cycle(1'b0, '0, 1'b1);
      step();
      step();
      check("sb_drained", 128'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
